// File: rtl/csr_pkg.sv
// csr_pkg: shared funct3 encodings, sequencer states and CSR numbers for the Zicsr execute path.
package csr_pkg;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_TIME     = 12'hC01;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;
  // funct3[1:0] alone selects the operation; 00 is the reserved encoding
  function automatic logic f3_legal(input logic [1:0] kind);
    return kind != 2'b00;
  endfunction
  function automatic logic f3_is_rw(input logic [1:0] kind);
    return kind == F3_CSRRW[1:0];
  endfunction
endpackage

// File: rtl/csr_access_unit_if.sv
// csr_access_unit_if: decode op, CSR file port and writeback result bundled between pipeline and sequencer.
interface csr_access_unit_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      op_valid;
  logic                      op_ready;
  logic [2:0]                op_funct3;
  logic [CSR_ADDR_WIDTH-1:0] op_csr_num;
  logic [REG_ADDR_WIDTH-1:0] op_rd;
  logic [REG_ADDR_WIDTH-1:0] op_rs1;
  logic [DATA_WIDTH-1:0]     op_rs1_value;
  logic [CSR_ADDR_WIDTH-1:0] csr_num;
  logic                      read_csr;
  logic                      write_csr;
  logic [2:0]                write_function;
  logic [DATA_WIDTH-1:0]     write_value;
  logic [DATA_WIDTH-1:0]     read_value;
  logic                      illegal_instr_exception;
  logic                      res_valid;
  logic                      res_ready;
  logic [REG_ADDR_WIDTH-1:0] res_rd;
  logic [DATA_WIDTH-1:0]     res_value;
  logic                      res_write_rd;
  logic                      res_exception;
  modport slave (
    input  op_valid, op_funct3, op_csr_num, op_rd, op_rs1, op_rs1_value,
    output op_ready,
    output csr_num, read_csr, write_csr, write_function, write_value,
    input  read_value, illegal_instr_exception,
    output res_valid, res_rd, res_value, res_write_rd, res_exception,
    input  res_ready
  );
  modport master (
    output op_valid, op_funct3, op_csr_num, op_rd, op_rs1, op_rs1_value,
    input  op_ready,
    input  csr_num, read_csr, write_csr, write_function, write_value,
    output read_value, illegal_instr_exception,
    input  res_valid, res_rd, res_value, res_write_rd, res_exception,
    output res_ready
  );
endinterface

// File: rtl/csr_access_unit_wdata_alu.sv
// csr_wdata_alu: merges the old CSR value with the source operand for RW/RS/RC writes.
module csr_wdata_alu
  import csr_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            i_kind,
  input  logic [DATA_WIDTH-1:0] i_old,
  input  logic [DATA_WIDTH-1:0] i_src,
  output logic [DATA_WIDTH-1:0] o_wdata
);
  always_comb
    o_wdata = (i_kind == F3_CSRRS[1:0]) ? (i_old | i_src) :
              (i_kind == F3_CSRRC[1:0]) ? (i_old & ~i_src) : i_src;
endmodule

// File: rtl/csr_access_unit.sv
// csr_access_unit: Zicsr read-modify-write sequencer between decode and the CSR file.
// Optional CSR_ACCESS_RO_CHECK_EN rejects writes into the read-only CSR space at accept.
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic clock,
  input logic reset_n,
  input logic flush,
  csr_access_unit_if.slave bus
);
  state_t                    r_state;
  logic                      r_op_ready, r_read, r_write, r_res_valid, r_exc;
  logic                      r_do_read, r_do_write;
  logic [2:0]                r_funct3;
  logic [CSR_ADDR_WIDTH-1:0] r_csr_num;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0]     r_src, r_old;
  logic                      w_accept, w_rw, w_do_read, w_do_write, w_ro, w_illegal;
  logic [DATA_WIDTH-1:0]     w_src, w_wdata;
  assign w_accept   = bus.op_valid && r_op_ready && !flush;
  assign w_rw       = f3_is_rw(bus.op_funct3[1:0]);
  assign w_src      = bus.op_funct3[2] ? {{(DATA_WIDTH-REG_ADDR_WIDTH){1'b0}}, bus.op_rs1} : bus.op_rs1_value;
  assign w_do_read  = !(w_rw && bus.op_rd == '0);
  assign w_do_write = w_rw || bus.op_rs1 != '0;
`ifdef CSR_ACCESS_RO_CHECK_EN
  assign w_ro = w_do_write && bus.op_csr_num[CSR_ADDR_WIDTH-1 -: 2] == 2'b11;
`else
  assign w_ro = 1'b0;
`endif
  assign w_illegal = !f3_legal(bus.op_funct3[1:0]) || w_ro;
  csr_wdata_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .i_kind  (r_funct3[1:0]),
    .i_old   (r_old),
    .i_src   (r_src),
    .o_wdata (w_wdata)
  );
  assign bus.op_ready       = r_op_ready;
  assign bus.csr_num        = r_csr_num;
  assign bus.read_csr       = r_read;
  assign bus.write_csr      = r_write;
  assign bus.write_function = r_funct3;
  assign bus.write_value    = w_wdata;
  assign bus.res_valid      = r_res_valid;
  assign bus.res_rd         = r_rd;
  assign bus.res_value      = r_exc ? '0 : r_old;
  assign bus.res_write_rd   = r_do_read && !r_exc && r_rd != '0;
  assign bus.res_exception  = r_exc;
  // strobes and res_valid are set on the edge entering their state, so they are glitch-free registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_op_ready  <= 1'b1;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_res_valid <= 1'b0;
      r_exc       <= 1'b0;
      r_do_read   <= 1'b0;
      r_do_write  <= 1'b0;
      r_funct3    <= '0;
      r_csr_num   <= '0;
      r_rd        <= '0;
      r_src       <= '0;
      r_old       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_funct3    <= bus.op_funct3;
          r_csr_num   <= bus.op_csr_num;
          r_rd        <= bus.op_rd;
          r_src       <= w_src;
          r_do_read   <= w_do_read;
          r_do_write  <= w_do_write;
          r_old       <= '0;
          r_exc       <= w_illegal;
          r_op_ready  <= 1'b0;
          r_res_valid <= w_illegal;
          r_read      <= !w_illegal && w_do_read;
          r_write     <= !w_illegal && !w_do_read;
          r_state     <= w_illegal ? S_RESP : w_do_read ? S_READ : S_WRITE;
        end
        S_READ: begin
          r_read      <= 1'b0;
          r_old       <= bus.read_value;
          r_exc       <= bus.illegal_instr_exception;
          r_op_ready  <= flush;
          r_res_valid <= !flush && (bus.illegal_instr_exception || !r_do_write);
          r_write     <= !flush && !bus.illegal_instr_exception && r_do_write;
          r_state     <= flush ? S_IDLE :
                         (bus.illegal_instr_exception || !r_do_write) ? S_RESP : S_WRITE;
        end
        // a flush here cannot cancel the strobe already on the bus, only the response
        S_WRITE: begin
          r_write     <= 1'b0;
          r_exc       <= bus.illegal_instr_exception;
          r_op_ready  <= flush;
          r_res_valid <= !flush;
          r_state     <= flush ? S_IDLE : S_RESP;
        end
        S_RESP: if (flush || bus.res_ready) begin
          r_res_valid <= 1'b0;
          r_op_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: scoreboarded bench with a CSR file model, directed corner cases and random ops.
module tb_csr_access_unit;
  import csr_pkg::*;
  localparam logic [11:0] BAD_CSR = 12'h7FF;
  typedef struct {
    logic [31:0] val;
    logic        wrd;
    logic        exc;
    logic [4:0]  rd;
    logic [11:0] csr;
    logic [2:0]  f3;
    logic [31:0] wv;
    int          reads;
    int          writes;
    int          acc;
  } exp_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic [31:0] mem [0:4095];
  exp_t q[$];
  exp_t cur;
  int total = 0, bad = 0, cyc = 0, rd_cnt = 0, wr_cnt = 0;
  bit seen = 0, rand_rr = 0, rr_val = 1;
  csr_access_unit_if bus ();
  csr_access_unit dut (.clock(clock), .reset_n(reset_n), .flush(flush), .bus(bus));
  assign bus.read_value = mem[bus.csr_num];
  assign bus.illegal_instr_exception = (bus.csr_num == BAD_CSR) && (bus.read_csr || bus.write_csr);
  initial forever #5 clock = ~clock;
  initial forever begin
    @(posedge clock);
    cyc++;
  end
  initial begin
    bus.res_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      bus.res_ready = rand_rr ? 1'($urandom_range(0, 1)) : rr_val;
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [2:0] f3, input logic [11:0] csr,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] v);
    exp_t e;
    logic rw, dr, dw, ro;
    logic [31:0] src, old;
    rw  = f3[1:0] == 2'b01;
    src = f3[2] ? {27'd0, rs1} : v;
    dr  = !(rw && rd == 5'd0);
    dw  = rw || rs1 != 5'd0;
    ro  = 1'b0;
`ifdef CSR_ACCESS_RO_CHECK_EN
    ro  = dw && csr[11:10] == 2'b11;
`endif
    old = dr ? mem[csr] : 32'd0;
    e.rd = rd; e.csr = csr; e.f3 = f3; e.acc = 0;
    e.wv = f3[1:0] == 2'b10 ? (old | src) : f3[1:0] == 2'b11 ? (old & ~src) : src;
    if (f3[1:0] == 2'b00 || ro) begin
      e.exc = 1'b1; e.reads = 0; e.writes = 0;
    end else begin
      e.exc    = csr == BAD_CSR;
      e.reads  = int'(dr);
      e.writes = (e.exc && dr) ? 0 : int'(dw);
    end
    e.val = e.exc ? 32'd0 : old;
    e.wrd = !e.exc && dr && rd != 5'd0;
    return e;
  endfunction
  task automatic do_op(input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [31:0] v, input bit track);
    exp_t e;
    int n = 0;
    @(negedge clock);
    while (!bus.op_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!bus.op_ready) begin
      chk("op_ready_timeout", 0, 1);
      return;
    end
    e = model(f3, csr, rd, rs1, v);
    e.acc = cyc + 1;
    cur = e;
    if (track) q.push_back(e);
    bus.op_funct3 = f3; bus.op_csr_num = csr; bus.op_rd = rd;
    bus.op_rs1 = rs1; bus.op_rs1_value = v; bus.op_valid = 1'b1;
    @(negedge clock);
    bus.op_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask
  task automatic wait_res_valid(input string tag);
    int n = 0;
    while (!bus.res_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk(tag, bus.res_valid, 1);
  endtask
  task automatic set_rr(input bit v);
    rr_val = v;
    @(posedge clock);
    #2;
  endtask
  // monitor: strobe accounting, write-port checks and result scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n) chk("rw_exclusive", bus.read_csr & bus.write_csr, 0);
      if (bus.read_csr) rd_cnt++;
      if (bus.write_csr) begin
        wr_cnt++;
        if (cur.csr != BAD_CSR) mem[cur.csr] = cur.wv;
        if (q.size() > 0) begin
          chk("write_value", bus.write_value, q[0].wv);
          chk("write_csr_num", bus.csr_num, q[0].csr);
          chk("write_function", bus.write_function, q[0].f3);
        end
      end
      if (bus.res_valid && q.size() > 0) begin
        if (!seen) begin
          chk("latency", cyc - q[0].acc, q[0].reads + q[0].writes);
          seen = 1;
        end
        if (bus.res_ready) begin
          e = q.pop_front();
          chk("res_value", bus.res_value, e.val);
          chk("res_write_rd", bus.res_write_rd, e.wrd);
          chk("res_exception", bus.res_exception, e.exc);
          chk("res_rd", bus.res_rd, e.rd);
          chk("read_strobes", rd_cnt, e.reads);
          chk("write_strobes", wr_cnt, e.writes);
          rd_cnt = 0; wr_cnt = 0; seen = 0;
        end
      end else if (bus.res_valid && bus.res_ready) begin
        chk("spurious_result", 1, 0);
      end
    end
  end
  initial begin
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    bus.op_valid = 1'b0; bus.op_funct3 = '0; bus.op_csr_num = '0;
    bus.op_rd = '0; bus.op_rs1 = '0; bus.op_rs1_value = '0;
    cur = model(F3_CSRRS, 12'h000, 5'd0, 5'd0, 32'd0);
    repeat (2) @(negedge clock);
    chk("rst_op_ready", bus.op_ready, 1);
    chk("rst_read_csr", bus.read_csr, 0);
    chk("rst_write_csr", bus.write_csr, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_exception", bus.res_exception, 0);
    chk("rst_res_value", bus.res_value, 0);
    reset_n = 1'b1;
    mem[CSR_CYCLE] = 32'h0000_0123;
    do_op(F3_CSRRS, CSR_CYCLE, 5'd5, 5'd0, 32'hDEAD_BEEF, 1);
    mem[CSR_MSTATUS] = 32'hFFFF_00FF;
    do_op(F3_CSRRC, CSR_MSTATUS, 5'd6, 5'd3, 32'h0000_000F, 1);
    do_op(F3_CSRRWI, CSR_MSCRATCH, 5'd0, 5'h1F, 32'hFFFF_FFFF, 1);
    do_op(3'b100, CSR_MSTATUS, 5'd7, 5'd1, 32'd5, 1);
    do_op(3'b000, CSR_MEPC, 5'd8, 5'd2, 32'd9, 1);
    do_op(F3_CSRRW, CSR_TIME, 5'd1, 5'd2, 32'h55, 1);
    do_op(F3_CSRRS, BAD_CSR, 5'd2, 5'd1, 32'd5, 1);
    do_op(F3_CSRRWI, BAD_CSR, 5'd0, 5'd4, 32'd0, 1);
    drain();
    set_rr(0);
    do_op(F3_CSRRS, BAD_CSR, 5'd3, 5'd1, 32'd5, 1);
    wait_res_valid("hold_reach");
    repeat (3) begin
      @(negedge clock);
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_exception", bus.res_exception, 1);
      chk("hold_value", bus.res_value, 0);
      chk("hold_rd", bus.res_rd, 3);
      chk("hold_op_ready", bus.op_ready, 0);
    end
    set_rr(1);
    drain();
    @(negedge clock);
    flush = 1'b1;
    bus.op_funct3 = F3_CSRRS; bus.op_csr_num = CSR_CYCLE; bus.op_rd = 5'd5; bus.op_rs1 = 5'd0;
    bus.op_valid = 1'b1;
    @(negedge clock);
    chk("fi_op_ready", bus.op_ready, 1);
    chk("fi_read_csr", bus.read_csr, 0);
    bus.op_valid = 1'b0;
    flush = 1'b0;
    @(negedge clock);
    chk("fi_read_after", bus.read_csr, 0);
    rd_cnt = 0; wr_cnt = 0;
    mem[CSR_MEPC] = 32'h0F0F_0F0F;
    do_op(F3_CSRRW, CSR_MEPC, 5'd1, 5'd2, 32'hA5A5_A5A5, 0);
    n = 0;
    while (!bus.write_csr && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("fw_strobe", bus.write_csr, 1);
    chk("fw_value", bus.write_value, 32'hA5A5_A5A5);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("fw_res_valid", bus.res_valid, 0);
    chk("fw_op_ready", bus.op_ready, 1);
    chk("fw_write_csr", bus.write_csr, 0);
    chk("fw_write_count", wr_cnt, 1);
    chk("fw_read_count", rd_cnt, 1);
    repeat (2) @(negedge clock);
    chk("fw_no_result", bus.res_valid, 0);
    set_rr(0);
    rd_cnt = 0; wr_cnt = 0;
    do_op(F3_CSRRS, CSR_CYCLE, 5'd5, 5'd0, 32'd0, 0);
    wait_res_valid("fr_reach");
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("fr_res_valid", bus.res_valid, 0);
    chk("fr_op_ready", bus.op_ready, 1);
    set_rr(1);
    rd_cnt = 0; wr_cnt = 0;
    do_op(F3_CSRRS, CSR_CYCLE, 5'd5, 5'd0, 32'd0, 0);
    chk("rr_in_read", bus.read_csr, 1);
    reset_n = 1'b0;
    @(negedge clock);
    chk("rr_read_csr", bus.read_csr, 0);
    chk("rr_write_csr", bus.write_csr, 0);
    chk("rr_res_valid", bus.res_valid, 0);
    chk("rr_op_ready", bus.op_ready, 1);
    chk("rr_res_value", bus.res_value, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rr_quiet", bus.read_csr | bus.write_csr | bus.res_valid, 0);
    rd_cnt = 0; wr_cnt = 0;
    rand_rr = 1;
    repeat (60) begin
      logic [11:0] csrs [6];
      csrs = '{CSR_MSTATUS, CSR_MSCRATCH, CSR_MEPC, CSR_CYCLE, CSR_TIME, BAD_CSR};
      do_op(3'($urandom_range(0, 7)), csrs[$urandom_range(0, 5)], 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom, 1);
    end
    drain();
    rand_rr = 0;
    set_rr(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
